// File: rtl/crc_rx_if.sv
// Handshake bundle between the serial CRC generator/consumer and crc_rx_checker.
interface crc_rx_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    logic                 Valid;
    logic                 CRC;
    logic                 Exp_Load;
    logic [WIDTH-1:0]     Exp_CRC;
    logic                 Out_Ready;
    logic                 Out_Valid;
    logic [WIDTH-1:0]     Out_CRC;
    logic                 Match;
    logic                 Frame_Err;
    logic                 Overrun;
    logic [ERR_CNT_W-1:0] Err_Count;

    modport master (
        output Valid, CRC, Exp_Load, Exp_CRC, Out_Ready,
        input  Out_Valid, Out_CRC, Match, Frame_Err, Overrun, Err_Count
    );

    modport slave (
        input  Valid, CRC, Exp_Load, Exp_CRC, Out_Ready,
        output Out_Valid, Out_CRC, Match, Frame_Err, Overrun, Err_Count
    );
endinterface

// File: rtl/crc_rx_checker.sv
// Serial LSB-first CRC receiver: assembles WIDTH bits, compares against a preloaded value.
// Optional mismatch counter enabled by defining CRC_RX_ERR_CNT_EN.
module crc_rx_checker #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic     CLK,
    input  logic     RST,
    crc_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] out_crc_q, out_crc_d;
    logic             out_valid_q, out_valid_d;
    logic             match_q, match_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             complete;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        exp_d       = exp_q;
        out_crc_d   = out_crc_q;
        out_valid_d = out_valid_q;
        match_d     = match_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        complete    = 1'b0;

        if (bus.Exp_Load)
            exp_d = bus.Exp_CRC;

        case (state_q)
            S_IDLE: begin
                if (bus.Valid) begin
                    shift_d[0] = bus.CRC;
                    bit_cnt_d  = CNT_W'(1);
                    state_d    = S_SHIFT;
                end
            end
            default: begin
                if (bus.Valid) begin
                    shift_d[bit_cnt_q] = bus.CRC;
                    if (bit_cnt_q == CNT_W'(WIDTH-1)) begin
                        complete  = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    state_d     = S_IDLE;
                end
            end
        endcase

        if (out_valid_q && bus.Out_Ready)
            out_valid_d = 1'b0;

        // A completing byte may reuse the slot the consumer is draining this cycle.
        if (complete) begin
            if (!out_valid_q || bus.Out_Ready) begin
                out_valid_d = 1'b1;
                out_crc_d   = shift_d;
                match_d     = (shift_d == exp_q);
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            exp_q       <= '0;
            out_crc_q   <= '0;
            out_valid_q <= 1'b0;
            match_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            exp_q       <= exp_d;
            out_crc_q   <= out_crc_d;
            out_valid_q <= out_valid_d;
            match_q     <= match_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.Out_Valid = out_valid_q;
    assign bus.Out_CRC   = out_crc_q;
    assign bus.Match     = match_q;
    assign bus.Frame_Err = frame_err_q;
    assign bus.Overrun   = overrun_q;

`ifdef CRC_RX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Only bytes that reach the output are counted; overrun drops are not.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (complete && (!out_valid_q || bus.Out_Ready) && (shift_d != exp_q) && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign bus.Err_Count = err_cnt_q;
`else
    assign bus.Err_Count = {ERR_CNT_W{1'b0}};
`endif
endmodule
